// File: rtl/pcg_rng_multi.sv
// Multi-channel PCG32 (XSH-RR) generator behind a single-beat bus slave with a shared multiplier.
// Each accepted transfer is acked exactly one cycle later; cyc/stb held high yields one transfer every two cycles.
module pcg_rng_multi #(
  parameter int          NCH       = 4,
  parameter logic [63:0] MULT_INIT = 64'h5851f42d4c957f2d,
  parameter logic [63:0] INC_INIT  = 64'h14057b7ef767814f,
  parameter logic [63:0] SEED_INIT = 64'h123456789abcdef0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat_w,
  output logic [31:0] dat_r,
  output logic        ack
);

  function automatic logic [31:0] xsh_rr(input logic [63:0] s);
    logic [31:0] x;
    logic [4:0]  r;
    x = 32'(((s >> 18) ^ s) >> 27);
    r = s[63:59];
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

  logic        acc;
  logic        wr;
  logic        rd;
  logic        glb;
  logic [28:0] blk;
  logic [2:0]  off;

  logic [1:0]  ctrl_q;
  logic [63:0] mult_q;
  logic [31:0] mult_sh_q;
  logic [63:0] state_q   [NCH];
  logic [63:0] inc_q     [NCH];
  logic [31:0] seed_sh_q [NCH];
  logic [31:0] inc_sh_q  [NCH];

  logic [NCH-1:0] hit;
  logic [NCH-1:0] step;
  logic [31:0]    rd_dat;

  assign acc = cyc & stb & ~ack;
  assign wr  = acc & we & (sel == 4'hF);
  assign rd  = acc & ~we;
  assign blk = adr[31:3];
  assign off = adr[2:0];
  assign glb = (adr[31:2] == 30'd0);

  // Channel c occupies word block c+1; blocks past NCH decode to nothing.
  always_comb begin
    hit  = '0;
    step = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c]  = (blk == 29'(c + 1));
      step[c] = ctrl_q[0] & (~ctrl_q[1] | (rd & hit[c] & (off == 3'd0)));
    end
  end

  always_comb begin
    rd_dat = 32'd0;
    if (glb) begin
      case (adr[1:0])
        2'd0:    rd_dat = {30'd0, ctrl_q};
        2'd1:    rd_dat = mult_q[63:32];
        2'd2:    rd_dat = mult_q[31:0];
        default: rd_dat = {24'd0, 8'(NCH)};
      endcase
    end
    for (int c = 0; c < NCH; c++) begin
      if (hit[c]) begin
        case (off)
          3'd0:    rd_dat = xsh_rr(state_q[c]);
          3'd1:    rd_dat = state_q[c][63:32];
          3'd2:    rd_dat = state_q[c][31:0];
          3'd3:    rd_dat = inc_q[c][63:32];
          3'd4:    rd_dat = inc_q[c][31:0];
          default: rd_dat = 32'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      dat_r     <= 32'd0;
      ctrl_q    <= 2'd0;
      mult_q    <= MULT_INIT;
      mult_sh_q <= 32'd0;
      for (int c = 0; c < NCH; c++) begin
        state_q[c]   <= SEED_INIT;
        inc_q[c]     <= INC_INIT + 64'(2 * c);
        seed_sh_q[c] <= 32'd0;
        inc_sh_q[c]  <= 32'd0;
      end
    end else begin
      ack <= acc;
      if (rd) dat_r <= rd_dat;

      if (wr && glb) begin
        case (adr[1:0])
          2'd0:    ctrl_q    <= dat_w[1:0];
          2'd1:    mult_sh_q <= dat_w;
          2'd2:    mult_q    <= {mult_sh_q, dat_w};
          default: ;
        endcase
      end

      // Nonblocking reads of mult_q/inc_q mean a same-edge commit only affects later steps.
      for (int c = 0; c < NCH; c++) begin
        if (wr && hit[c] && (off == 3'd2))
          state_q[c] <= {seed_sh_q[c], dat_w};
        else if (step[c])
          state_q[c] <= state_q[c] * mult_q + inc_q[c];

        if (wr && hit[c]) begin
          case (off)
            3'd1:    seed_sh_q[c] <= dat_w;
            3'd3:    inc_sh_q[c]  <= dat_w;
            3'd4:    inc_q[c]     <= {inc_sh_q[c], dat_w[31:1], 1'b1};
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pcg_rng_multi.sv
// Bench for pcg_rng_multi: directed register-map scenarios plus randomized free-run traffic against a register-level model.
module tb_pcg_rng_multi;
  localparam int          NCH       = 4;
  localparam logic [63:0] MULT_INIT = 64'h5851f42d4c957f2d;
  localparam logic [63:0] INC_INIT  = 64'h14057b7ef767814f;
  localparam logic [63:0] SEED_INIT = 64'h123456789abcdef0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic [31:0] dat_r;
  logic        ack;

  int checks = 0;
  int failures = 0;

  pcg_rng_multi #(
    .NCH(NCH), .MULT_INIT(MULT_INIT), .INC_INIT(INC_INIT), .SEED_INIT(SEED_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
    .adr(adr), .dat_w(dat_w), .dat_r(dat_r), .ack(ack)
  );

  always #5 clk = ~clk;

  // Register-level reference model.
  logic [1:0]  m_ctrl;
  logic [63:0] m_mult;
  logic [31:0] m_msh;
  logic [63:0] m_st  [NCH];
  logic [63:0] m_inc [NCH];
  logic [31:0] m_ssh [NCH];
  logic [31:0] m_ish [NCH];
  logic        m_ack;
  logic [31:0] m_dat;

  function automatic logic [31:0] pcg_out(input logic [63:0] s);
    logic [63:0] t;
    logic [31:0] x;
    int r;
    t = ((s >> 18) ^ s) >> 27;
    x = t[31:0];
    r = int'(s >> 59);
    return (x >> r) | (x << ((32 - r) % 32));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int c, o;
    logic [63:0] v;
    if (a == 0) return {30'd0, m_ctrl};
    if (a == 1) return m_mult[63:32];
    if (a == 2) return m_mult[31:0];
    if (a == 3) return NCH;
    if (a >= 8 && a < 8 + 8 * NCH) begin
      c = (int'(a) - 8) / 8;
      o = (int'(a) - 8) % 8;
      if (o == 0) return pcg_out(m_st[c]);
      v = (o == 1 || o == 2) ? m_st[c] : m_inc[c];
      if (o == 1 || o == 3) return v[63:32];
      if (o == 2 || o == 4) return v[31:0];
    end
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_ctrl = 2'd0; m_mult = MULT_INIT; m_msh = 32'd0; m_ack = 1'b0; m_dat = 32'd0;
    for (int k = 0; k < NCH; k++) begin
      m_st[k] = SEED_INIT; m_inc[k] = INC_INIT + 64'(2 * k); m_ssh[k] = 32'd0; m_ish[k] = 32'd0;
    end
  endtask

  // Advance the model by one clock edge using the current bus inputs, then let the DUT take that edge.
  task automatic tick();
    logic [63:0] nst [NCH];
    bit acc, wr, rdx, chm;
    int c, o;
    acc = cyc && stb && !m_ack;
    wr  = acc && we && (sel == 4'hF);
    rdx = acc && !we;
    chm = (adr >= 8) && (adr < 8 + 8 * NCH);
    c = chm ? (int'(adr) - 8) / 8 : 0;
    o = chm ? (int'(adr) - 8) % 8 : 7;
    if (rdx) m_dat = m_read(adr);
    for (int k = 0; k < NCH; k++) begin
      nst[k] = m_st[k];
      if (m_ctrl[0] && (!m_ctrl[1] || (rdx && chm && c == k && o == 0)))
        nst[k] = m_st[k] * m_mult + m_inc[k];
    end
    if (wr) begin
      if (adr == 0) m_ctrl = dat_w[1:0];
      else if (adr == 1) m_msh = dat_w;
      else if (adr == 2) m_mult = {m_msh, dat_w};
      else if (chm) begin
        if (o == 1) m_ssh[c] = dat_w;
        if (o == 2) nst[c] = {m_ssh[c], dat_w};
        if (o == 3) m_ish[c] = dat_w;
        if (o == 4) m_inc[c] = {m_ish[c], dat_w} | 64'd1;
      end
    end
    for (int k = 0; k < NCH; k++) m_st[k] = nst[k];
    m_ack = acc;
    @(posedge clk); #1;
  endtask

  task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output logic a1, output logic a2);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    tick();
    a1 = ack; rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    a2 = ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat_w = 32'd0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic a1, a2;
    checks++;
    if (ack !== 1'b0 || dat_r !== 32'd0) begin
      failures++; $display("FAIL reset_outputs ack=%b dat_r=%h expected ack=0 dat_r=0", ack, dat_r);
    end
    bus(0, 32'd3, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h4) begin failures++; $display("FAIL info got=%h exp=00000004", rd); end
    checks++;
    if (a1 !== 1'b1 || a2 !== 1'b0) begin failures++; $display("FAIL ack_pulse got=%b%b exp=10", a1, a2); end
    bus(0, 32'd0, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL ctrl_reset got=%h exp=00000000", rd); end
    bus(0, 32'd1, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h5851f42d || a1 !== 1'b1 || a2 !== 1'b0) begin
      failures++; $display("FAIL mult_hi_reset got=%h ack=%b%b exp=5851f42d ack=10", rd, a1, a2);
    end
  endtask

  task automatic test_step_on_read();
    logic [31:0] rd; logic a1, a2;
    bus(1, 32'd0, 4'hF, 32'd3, rd, a1, a2);
    bus(1, 32'd9, 4'hF, 32'd0, rd, a1, a2);
    bus(1, 32'd10, 4'hF, 32'd0, rd, a1, a2);
    bus(0, 32'd8, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL step_read_first got=%h exp=00000000", rd); end
    bus(0, 32'd8, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== pcg_out(INC_INIT)) begin
      failures++; $display("FAIL step_read_second got=%h exp=%h", rd, pcg_out(INC_INIT));
    end
    bus(0, 32'd16, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== pcg_out(SEED_INIT)) begin
      failures++; $display("FAIL ch1_untouched got=%h exp=%h", rd, pcg_out(SEED_INIT));
    end
  endtask

  task automatic test_no_step();
    logic [31:0] rd; logic a1, a2;
    bus(1, 32'd0, 4'hF, 32'd0, rd, a1, a2);
    bus(1, 32'd25, 4'hF, 32'h08000000, rd, a1, a2);
    bus(1, 32'd26, 4'hF, 32'd0, rd, a1, a2);
    for (int i = 0; i < 2; i++) begin
      bus(0, 32'd24, 4'hF, 32'd0, rd, a1, a2);
      checks++;
      if (rd !== 32'h00002000) begin failures++; $display("FAIL no_step_read%0d got=%h exp=00002000", i, rd); end
    end
  endtask

  task automatic test_inc_force();
    logic [31:0] rd; logic a1, a2;
    bus(1, 32'd11, 4'hF, 32'd0, rd, a1, a2);
    bus(1, 32'd12, 4'hF, 32'd2, rd, a1, a2);
    bus(0, 32'd12, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h3) begin failures++; $display("FAIL inc_lsb_forced got=%h exp=00000003", rd); end
    bus(1, 32'd0, 4'h3, 32'd3, rd, a1, a2);
    checks++;
    if (a1 !== 1'b1 || a2 !== 1'b0) begin failures++; $display("FAIL partial_write_ack got=%b%b exp=10", a1, a2); end
    bus(0, 32'd0, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL partial_write_ignored got=%h exp=00000000", rd); end
    bus(0, 32'(8 + 8 * NCH), 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h0 || a1 !== 1'b1) begin failures++; $display("FAIL unmapped_read got=%h ack=%b exp=0 ack=1", rd, a1); end
  endtask

  task automatic test_back_to_back();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd3; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (ack !== ((i % 2) == 0)) begin failures++; $display("FAIL b2b_ack%0d got=%b exp=%b", i, ack, (i % 2) == 0); end
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
  endtask

  task automatic test_free_run();
    logic [31:0] rd; logic a1, a2;
    int c, o;
    bus(1, 32'd0, 4'hF, 32'd1, rd, a1, a2);
    for (int i = 0; i < 100; i++) begin
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1);
      c = $urandom_range(0, NCH - 1);
      case ($urandom_range(0, 6))
        0, 1:    o = 0;
        2, 3:    o = 2;
        4:       o = 1;
        5:       o = 4;
        default: o = 5;
      endcase
      adr = ($urandom_range(0, 15) == 0) ? 32'(8 + 8 * NCH) : 32'(8 + 8 * c + o);
      sel = ($urandom_range(0, 5) == 0) ? 4'h3 : 4'hF;
      dat_w = $urandom;
      tick();
      checks++;
      if (ack !== m_ack) begin failures++; $display("FAIL free_ack cyc%0d got=%b exp=%b", i, ack, m_ack); end
      checks++;
      if (dat_r !== m_dat) begin failures++; $display("FAIL free_dat cyc%0d got=%h exp=%h", i, dat_r, m_dat); end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    for (int k = 0; k < NCH; k++) begin
      bus(0, 32'(8 + 8 * k), 4'hF, 32'd0, rd, a1, a2);
      checks++;
      if (rd !== m_dat) begin failures++; $display("FAIL free_out_ch%0d got=%h exp=%h", k, rd, m_dat); end
    end
    bus(1, 32'd0, 4'hF, 32'd0, rd, a1, a2);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic a1, a2;
    bus(1, 32'd1, 4'hF, 32'hdeadbeef, rd, a1, a2);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd2; sel = 4'hF; dat_w = 32'h12345678;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", ack); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
    bus(0, 32'd1, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h5851f42d) begin failures++; $display("FAIL abort_mult_hi got=%h exp=5851f42d", rd); end
    bus(0, 32'd2, 4'hF, 32'd0, rd, a1, a2);
    checks++;
    if (rd !== 32'h4c957f2d) begin failures++; $display("FAIL abort_mult_lo got=%h exp=4c957f2d", rd); end
    for (int k = 0; k < NCH; k++) begin
      bus(0, 32'(8 + 8 * k), 4'hF, 32'd0, rd, a1, a2);
      checks++;
      if (rd !== pcg_out(SEED_INIT)) begin
        failures++; $display("FAIL abort_out_ch%0d got=%h exp=%h", k, rd, pcg_out(SEED_INIT));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_step_on_read();
    test_no_step();
    test_inc_force();
    test_back_to_back();
    test_free_run();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcg_rng_multi.md
PCG_RNG_MULTI -- requirements
Module: pcg_rng_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent generator channels (legal 1..8).
REQ-002 SHALL have parameter MULT_INIT, default 64'h5851f42d4c957f2d, reset value of the shared multiplier.
REQ-003 SHALL have parameter INC_INIT, default 64'h14057b7ef767814f, base reset increment; channel c resets to INC_INIT + 2*c.
REQ-004 SHALL have parameter SEED_INIT, default 64'h123456789abcdef0, reset state of every channel.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cyc and stb, input, 1 each, bus cycle and strobe.
REQ-008 SHALL have port we, input, 1, write enable.
REQ-009 SHALL have port sel, input, 4, byte selects.
REQ-010 SHALL have port adr, input, 32, word address.
REQ-011 SHALL have port dat_w, input, 32, write data.
REQ-012 SHALL have port dat_r, output, 32, registered read data.
REQ-013 SHALL have port ack, output, 1, transfer acknowledge.

Function
REQ-014 SHALL accept a transfer on an edge where cyc & stb & !ack; ack SHALL be 1 exactly the following cycle, then 0 (one-cycle pulse, one wait-free transfer per two cycles max).
REQ-015 SHALL update dat_r only on accepted reads, valid while ack=1, and hold it otherwise; unmapped reads return 0.
REQ-016 SHALL apply writes only when sel==4'hF; partial, unmapped, or read-only-target writes are ignored but still acked.
REQ-017 Global map: 0 CTRL rw (bit0 EN, bit1 MODE: 0 free-run, 1 step-on-read, others read 0); 1 MULT_HI rw; 2 MULT_LO rw; 3 INFO ro = {24'h0, NCH[7:0]}.
REQ-018 Channel map, base 8+8*c for c<NCH: +0 OUT ro; +1 SEED_HI; +2 SEED_LO; +3 INC_HI; +4 INC_LO; +5..+7 and c>=NCH unmapped.
REQ-019 HI writes SHALL go to a per-register shadow; the LO write SHALL commit {shadow, dat_w} atomically; HI reads return the live upper word.
REQ-020 Committed increment SHALL have bit0 forced to 1; multiplier committed as written.
REQ-021 Step: state <= (state*mult + inc) mod 2^64, all arithmetic truncated to 64 bits.
REQ-022 OUT SHALL be XSH-RR of the current pre-step state s: x = ((s>>18)^s)>>27 truncated to 32 bits, r = s[63:59], OUT = x rotated right by r.
REQ-023 EN=0: no channel steps in either mode.
REQ-024 MODE=0, EN=1: every channel steps every cycle; OUT read samples state at the accept edge.
REQ-025 MODE=1, EN=1: channel c steps only on the accept edge of a read of its OUT; dat_r holds the pre-step permutation.
REQ-026 Seed commit and step on the same edge: seed wins; state equals the seed exactly.
REQ-027 Multiplier or increment commit on the same edge as a step: the step uses old values; new values apply from the next step.
REQ-028 CTRL write affects stepping from the edge after commit.
REQ-029 Channels SHALL be fully independent apart from the shared multiplier, EN and MODE.

Reset
REQ-030 rst_n=0 SHALL asynchronously set: ack=0, dat_r=0, CTRL=0, mult=MULT_INIT, inc[c]=INC_INIT+2*c, state[c]=SEED_INIT, all shadows=0.
REQ-031 Reset asserted mid-transfer SHALL abort it with no ack and no write effect; deassertion is synchronised by the integrator; first transfer is accepted on the first edge after release.

Verification
REQ-032 After reset: read INFO -> 0x00000004; read CTRL -> 0; read MULT_HI -> 0x5851f42d; each ack exactly one cycle wide.
REQ-033 MODE=1, EN=1, seed ch0 = 0 (SEED_HI=0, SEED_LO=0): read OUT0 -> 0; next read OUT0 -> XSH-RR(0x14057b7ef767814f) per model; ch1 unchanged.
REQ-034 Seed ch2 = 0x0800000000000000, EN=0: read OUT2 -> 0x00002000 twice (no step).
REQ-035 Write INC_HI=0, INC_LO=0x2 on ch0: read INC_LO -> 0x00000003; sel=4'h3 write to CTRL -> CTRL unchanged, ack still pulses.
REQ-036 MODE=0, EN=1 for 100 cycles, random cyc/stb and SEED_LO commits landing on step edges: all OUT reads match cycle-accurate model; seed-collision edges leave state == seed.
REQ-037 Assert rst_n low during a pending write to MULT_LO: no ack, mult reads back 0x5851f42d4c957f2d, all channels return SEED_INIT permutation.
